upg_tx_dump: RTL

// - Transmit side of the UART programmer link: reads back data-memory words and sends them over tx, 8N1, LSB first.
// - Sits beside uart_bmpg_0 in the upg_clk domain. Drives the same 15-bit word-address / 32-bit data memory port that the programmer writes.
// - Each word goes out as 4 bytes, little-endian (byte 0 = dat[7:0] first), so a host can verify a download.

---
 rtl/upg_tx_dump_pkg.sv | 29 ++
 rtl/upg_tx_dump_uart_tx_byte.sv | 66 ++++++
 rtl/upg_tx_dump.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/upg_tx_dump_pkg.sv
// Shared definitions for the UART programmer transmit path: word FSM states,
// frame geometry and the word-to-byte selector.
package upg_tx_dump_pkg;

   localparam int UART_FRAME_BITS = 32'd10;
   localparam int BYTES_PER_WORD  = 32'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADR  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_SEND    = 3'd3,
      ST_FIN     = 3'd4
   } upg_state_e;

   // Little-endian byte lane select: lane 0 is transmitted first.
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] res;
      case (idx)
         2'd0:    res = word[7:0];
         2'd1:    res = word[15:8];
         2'd2:    res = word[23:16];
         2'd3:    res = word[31:24];
         default: res = word[7:0];
      endcase
      return res;
   endfunction

endpackage

// File: rtl/upg_tx_dump_uart_tx_byte.sv
// 8N1 byte serializer, LSB first. ready_o is also high in the final cycle of
// the stop bit so the next byte can follow with no idle gap.
module upg_tx_dump_uart_tx_byte
   import upg_tx_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 78
) (
   input  logic       upg_clk_i,
   input  logic       upg_rst_i,
   input  logic [7:0] byte_i,
   input  logic       valid_i,
   output logic       tx_o,
   output logic       ready_o
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   logic              active_r;
   logic [3:0]        bit_cnt_r;
   logic [BAUD_W-1:0] baud_cnt_r;
   logic [7:0]        data_r;
   logic              tx_r;
   logic              baud_last_s;
   logic              bit_last_s;
   logic              ready_s;

   assign baud_last_s = (baud_cnt_r == BAUD_W'(CLKS_PER_BIT - 1));
   assign bit_last_s  = (bit_cnt_r == 4'(UART_FRAME_BITS - 1));
   assign ready_s     = !active_r || (bit_last_s && baud_last_s);
   assign ready_o     = ready_s;
   assign tx_o        = tx_r;

   // Bit timing and shift register; a new byte always wins over finishing the frame.
   always_ff @(posedge upg_clk_i) begin
      if (upg_rst_i) begin
         active_r   <= 1'b0;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= {BAUD_W{1'b0}};
         data_r     <= 8'h00;
         tx_r       <= 1'b1;
      end else if (valid_i && ready_s) begin
         active_r   <= 1'b1;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= {BAUD_W{1'b0}};
         data_r     <= byte_i;
         tx_r       <= 1'b0;
      end else if (active_r) begin
         if (baud_last_s) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            if (bit_last_s) begin
               active_r  <= 1'b0;
               bit_cnt_r <= 4'd0;
               tx_r      <= 1'b1;
            end else begin
               // Ones shift in from the top, so the ninth shift yields the stop level.
               bit_cnt_r <= bit_cnt_r + 4'd1;
               tx_r      <= data_r[0];
               data_r    <= {1'b1, data_r[7:1]};
            end
         end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
         end
      end
   end

endmodule

// File: rtl/upg_tx_dump.sv
// Reads data-memory words and streams them over upg_tx_o as 4 little-endian
// 8N1 bytes each, back-to-back, for host-side download verification.
module upg_tx_dump
   import upg_tx_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 78,
   parameter int ADR_W        = 15,
   parameter int CNT_W        = 16
) (
   input  logic             upg_clk_i,
   input  logic             upg_rst_i,
   input  logic             start_i,
   input  logic [ADR_W-1:0] base_adr_i,
   input  logic [CNT_W-1:0] word_cnt_i,
   output logic [ADR_W-1:0] mem_adr_o,
   input  logic [31:0]      mem_dat_i,
   output logic             upg_tx_o,
   output logic             busy_o,
   output logic             done_o
);

   upg_state_e       state_r;
   upg_state_e       state_s;
   logic [ADR_W-1:0] adr_r;
   logic [CNT_W-1:0] rem_r;
   logic [31:0]      word_r;
   logic [1:0]       byte_idx_r;
   logic             busy_r;
   logic             done_r;
   logic             tx_valid_s;
   logic [7:0]       tx_byte_s;
   logic             tx_ready_s;
   logic             accept_s;
   logic             last_byte_s;
   logic             more_words_s;

   assign accept_s     = tx_valid_s && tx_ready_s;
   assign last_byte_s  = (byte_idx_r == 2'(BYTES_PER_WORD - 1));
   assign more_words_s = (rem_r > CNT_W'(1));
   assign mem_adr_o    = adr_r;
   assign busy_o       = busy_r;
   assign done_o       = done_r;

   upg_tx_dump_uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .upg_clk_i(upg_clk_i),
      .upg_rst_i(upg_rst_i),
      .byte_i   (tx_byte_s),
      .valid_i  (tx_valid_s),
      .tx_o     (upg_tx_o),
      .ready_o  (tx_ready_s)
   );

   // Word FSM state register.
   always_ff @(posedge upg_clk_i) begin
      if (upg_rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and byte handoff. Byte 0 is fed straight from the BRAM in
   // RD_WAIT; rem_r==0 inside SEND means the last byte is still draining.
   always_comb begin
      state_s    = state_r;
      tx_valid_s = 1'b0;
      tx_byte_s  = byte_sel(word_r, byte_idx_r);
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               if (word_cnt_i == {CNT_W{1'b0}}) begin
                  state_s = ST_FIN;
               end else begin
                  state_s = ST_RD_ADR;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD_ADR: begin
            state_s = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            tx_valid_s = 1'b1;
            tx_byte_s  = mem_dat_i[7:0];
            state_s    = ST_SEND;
         end
         ST_SEND: begin
            if (rem_r == {CNT_W{1'b0}}) begin
               if (tx_ready_s) begin
                  state_s = ST_FIN;
               end else begin
                  state_s = ST_SEND;
               end
            end else begin
               tx_valid_s = 1'b1;
               // Prefetch the next word as soon as the last byte is handed over.
               if (tx_ready_s && last_byte_s && more_words_s) begin
                  state_s = ST_RD_ADR;
               end else begin
                  state_s = ST_SEND;
               end
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Address, count, word buffer and registered status outputs.
   always_ff @(posedge upg_clk_i) begin
      if (upg_rst_i) begin
         adr_r      <= {ADR_W{1'b0}};
         rem_r      <= {CNT_W{1'b0}};
         word_r     <= 32'h0000_0000;
         byte_idx_r <= 2'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         busy_r <= (state_s == ST_RD_ADR) || (state_s == ST_RD_WAIT) || (state_s == ST_SEND);
         done_r <= (state_s == ST_FIN);
         if ((state_r == ST_IDLE) && start_i) begin
            adr_r      <= base_adr_i;
            rem_r      <= word_cnt_i;
            byte_idx_r <= 2'd0;
         end else if (accept_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            if (last_byte_s) begin
               rem_r <= rem_r - CNT_W'(1);
               if (more_words_s) begin
                  adr_r <= adr_r + ADR_W'(1);
               end
            end
         end
         if (state_r == ST_RD_WAIT) begin
            word_r <= mem_dat_i;
         end
      end
   end

endmodule
